// File: rtl/j_shifter_pkg.sv
// rtl/j_shifter_pkg.sv - shared constants and state type for the j-array activation shifter
// Purpose: word/stride/bit-counter widths, default SRAM geometry and the FSM encoding.
// Ports: none (package).
package j_shifter_pkg;
  localparam int WORD_W         = 32;
  localparam int ADDR_STRIDE    = 4;
  localparam int BIT_CNT_W      = 5;
  localparam int SRAM_DEPTH_DEF = 256 * 256 * 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/j_act_shifter_if.sv
// rtl/j_act_shifter_if.sv - SRAM read, control and serial stream bundle of the shifter
// Purpose: groups every non-clock/reset signal of j_act_shifter.
// Ports: master = shifter side (drives sram_en/sram_addr/shift_idle/serial_*),
//        slave  = SRAM + controller + consumer side.
// Optional: shift_abort exists only when J_SHIFTER_ABORT_EN is defined.
interface j_act_shifter_if #(
  parameter int SRAM_ADDR_W = 18
) ();
  logic                   sram_en;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [31:0]            sram_rdata;
  logic                   shift_start;
  logic                   shift_idle;
  logic [SRAM_ADDR_W-1:0] start_addr;
  logic [SRAM_ADDR_W-1:0] img_size;
  logic                   serial_output;
  logic                   serial_en;
  logic                   serial_ready;
`ifdef J_SHIFTER_ABORT_EN
  logic                   shift_abort;
`endif

  modport master (
    output sram_en, sram_addr, shift_idle, serial_output, serial_en,
    input  sram_rdata, shift_start, start_addr, img_size, serial_ready
`ifdef J_SHIFTER_ABORT_EN
    , input shift_abort
`endif
  );

  modport slave (
    input  sram_en, sram_addr, shift_idle, serial_output, serial_en,
    output sram_rdata, shift_start, start_addr, img_size, serial_ready
`ifdef J_SHIFTER_ABORT_EN
    , output shift_abort
`endif
  );
endinterface

// File: rtl/j_word_prefetch_buf.sv
// rtl/j_word_prefetch_buf.sv - one-entry word buffer between SRAM read data and the shift register
// Ports: clk, reset (async, active-high); flush_i empties the slot; load_i writes data_i;
//        drain_i marks the slot consumed; valid_o/data_o expose the held word.
// Load and drain in the same cycle keep the slot full with the new word.
module j_word_prefetch_buf
  import j_shifter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o
);
  logic              valid_q;
  logic [WORD_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/j_act_shifter.sv
// rtl/j_act_shifter.sv - SRAM-to-bit-serial activation shifter for the j-array input path
// Purpose: on shift_start reads img_size+1 words from start_addr (stride 4) and streams each
//          word LSB-first, one bit per accepted cycle, with a prefetch slot hiding read latency.
// Ports: clk, reset (async, active-high); bus (j_act_shifter_if.master): SRAM read port,
//        start/idle control, serial_output/serial_en/serial_ready stream.
// Optional: J_SHIFTER_ABORT_EN adds shift_abort (cancels a running transfer).
module j_act_shifter
  import j_shifter_pkg::*;
#(
  parameter int SRAM_DEPTH  = SRAM_DEPTH_DEF,
  parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH)
) (
  input logic                clk,
  input logic                reset,
  j_act_shifter_if.master    bus
);
  state_t                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] img_size_q, addr_q, words_done_q;
  logic [SRAM_ADDR_W:0]   words_issued_q;
  logic                   sram_en_q, rvalid_q, sh_valid_q;
  logic [WORD_W-1:0]      shreg_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;

  logic abort, start, kill, xfer, last_bit, done, active, sh_load;
  logic pf_valid, pf_load, pf_drain, issue;
  logic [WORD_W-1:0] pf_data;

`ifdef J_SHIFTER_ABORT_EN
  assign abort = bus.shift_abort;
`else
  assign abort = 1'b0;
`endif

  assign start    = (state_q == S_IDLE) && bus.shift_start;
  assign kill     = (state_q == S_SHIFT) && abort;
  assign xfer     = sh_valid_q && bus.serial_ready;
  assign last_bit = xfer && (&bit_cnt_q);
  assign done     = last_bit && (words_done_q == img_size_q);
  assign active   = (state_q == S_SHIFT) && !kill && !done;
  // Shift register takes a new word when empty or when its last bit leaves this cycle.
  assign sh_load  = !sh_valid_q || last_bit;
  assign pf_drain = active && sh_load && pf_valid;
  // Read data bypasses the slot only when the shift register wants it and nothing older waits.
  assign pf_load  = active && rvalid_q && !(sh_load && !pf_valid);
  // Single outstanding read: nothing issued last cycle and nothing landing this cycle.
  assign issue    = active && !sram_en_q && !rvalid_q && (!pf_valid || pf_drain) &&
                    ({1'b0, img_size_q} >= words_issued_q);

  j_word_prefetch_buf u_pf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (kill || done),
    .load_i  (pf_load),
    .drain_i (pf_drain),
    .data_i  (bus.sram_rdata),
    .valid_o (pf_valid),
    .data_o  (pf_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.shift_start) state_d = S_SHIFT;
      S_SHIFT: if (kill || done)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_size_q     <= '0;
      addr_q         <= '0;
      words_issued_q <= '0;
      words_done_q   <= '0;
      sram_en_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      sh_valid_q     <= 1'b0;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
    end else begin
      rvalid_q <= sram_en_q && !kill;
      if (start) begin
        img_size_q     <= bus.img_size;
        addr_q         <= bus.start_addr;
        sram_en_q      <= 1'b1;
        words_issued_q <= (SRAM_ADDR_W+1)'(1);
        words_done_q   <= '0;
        bit_cnt_q      <= '0;
        sh_valid_q     <= 1'b0;
      end else begin
        sram_en_q <= issue;
        if (issue) begin
          addr_q         <= addr_q + SRAM_ADDR_W'(ADDR_STRIDE);
          words_issued_q <= words_issued_q + (SRAM_ADDR_W+1)'(1);
        end
      end

      if (kill || done) begin
        sh_valid_q <= 1'b0;
        shreg_q    <= '0;
        bit_cnt_q  <= '0;
      end else if (state_q == S_SHIFT) begin
        if (xfer) begin
          shreg_q   <= shreg_q >> 1;
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
        end
        if (last_bit) words_done_q <= words_done_q + SRAM_ADDR_W'(1);
        if (sh_load) begin
          if (pf_valid) begin
            shreg_q    <= pf_data;
            sh_valid_q <= 1'b1;
          end else if (rvalid_q) begin
            shreg_q    <= bus.sram_rdata;
            sh_valid_q <= 1'b1;
          end else begin
            sh_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  // Read gating must never deliver a word while both the shift register and the slot are full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(state_q == S_SHIFT && rvalid_q && pf_valid && !pf_drain));

  assign bus.sram_en       = sram_en_q;
  assign bus.sram_addr     = addr_q;
  assign bus.shift_idle    = (state_q == S_IDLE);
  assign bus.serial_output = shreg_q[0];
  assign bus.serial_en     = sh_valid_q;
endmodule

// File: tb/tb_j_act_shifter.sv
// tb/tb_j_act_shifter.sv - self-checking bench for j_act_shifter
module tb_j_act_shifter;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  j_act_shifter_if #(.SRAM_ADDR_W(AW)) bus ();

  j_act_shifter #(.SRAM_DEPTH(256 * 256 * 4), .SRAM_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]   mem [int unsigned];
  logic [AW-1:0] rd_q [$];
  logic          bit_q [$];
  int            t_q [$];
  logic          hold_p = 1'b0;
  logic          hold_bit = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    int unsigned k = int'(a);
    if (mem.exists(k)) return mem[k];
    return 32'h9E37_79B9 ^ (k * 32'h0101_0101) ^ {k[15:0], 16'h5A3C};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model (1-cycle read latency) plus transfer recorder.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sram_en) begin
      bus.sram_rdata <= mem_rd(bus.sram_addr);
      rd_q.push_back(bus.sram_addr);
    end
    if (!reset && bus.serial_en && bus.serial_ready) begin
      bit_q.push_back(bus.serial_output);
      t_q.push_back(cyc);
    end
    hold_p   <= !reset && bus.serial_en && !bus.serial_ready;
    hold_bit <= bus.serial_output;
  end

  // A stalled bit must stay presented unchanged after the edge.
  always @(negedge clk) begin
    if (hold_p && !reset) begin
      check("hold_en", 64'(bus.serial_en), 64'd1);
      check("hold_bit", 64'(bus.serial_output), 64'(hold_bit));
    end
  end

  task automatic run(input logic [AW-1:0] sa, input logic [AW-1:0] sz, input bit rnd,
                     input bit restart, input bit lat, input string tag);
    logic [AW-1:0] exp_a [$];
    logic [31:0]   exp_w [$];
    logic [AW-1:0] a;
    logic [31:0]   w;
    int            n;
    for (int i = 0; i <= int'(sz); i++) begin
      a = sa + AW'(4 * i);
      exp_a.push_back(a);
      exp_w.push_back(mem_rd(a));
    end
    rd_q.delete(); bit_q.delete(); t_q.delete();
    bus.start_addr   = sa;
    bus.img_size     = sz;
    bus.shift_start  = 1'b1;
    bus.serial_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    bus.shift_start = 1'b0;
    bus.start_addr  = sa + AW'(64);
    bus.img_size    = '0;
    n = 0;
    while (!bus.shift_idle && n < 5000) begin
      if (lat && n == 0) begin
        check({tag, "_c1_sram_en"}, 64'(bus.sram_en), 64'd1);
        check({tag, "_c1_addr"}, 64'(bus.sram_addr), 64'(sa));
        check({tag, "_c1_ser_en"}, 64'(bus.serial_en), 64'd0);
      end
      if (lat && n == 1) check({tag, "_c2_ser_en"}, 64'(bus.serial_en), 64'd0);
      if (lat && n == 2) begin
        check({tag, "_c3_ser_en"}, 64'(bus.serial_en), 64'd1);
        check({tag, "_c3_bit0"}, 64'(bus.serial_output), 64'(exp_w[0][0]));
      end
      if (rnd) bus.serial_ready = 1'($urandom_range(0, 1));
      if (restart && n == 40) begin
        bus.shift_start = 1'b1;
        bus.start_addr  = AW'(32'h80);
        bus.img_size    = AW'(5);
      end else begin
        bus.shift_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.shift_start  = 1'b0;
    bus.serial_ready = 1'b1;
    check({tag, "_timeout"}, 64'(n < 5000), 64'd1);
    check({tag, "_nreads"}, 64'(rd_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++)
      check($sformatf("%s_rdaddr%0d", tag, i), 64'(rd_q[i]), 64'(exp_a[i]));
    check({tag, "_nbits"}, 64'(bit_q.size()), 64'(32 * exp_w.size()));
    for (int i = 0; i < exp_w.size() && 32 * i + 31 < bit_q.size(); i++) begin
      for (int b = 0; b < 32; b++) w[b] = bit_q[32 * i + b];
      check($sformatf("%s_word%0d", tag, i), 64'(w), 64'(exp_w[i]));
    end
    if (!rnd && t_q.size() > 0)
      check({tag, "_contig"}, 64'(t_q[t_q.size() - 1] - t_q[0]), 64'(t_q.size() - 1));
    check({tag, "_end_ser_en"}, 64'(bus.serial_en), 64'd0);
    check({tag, "_end_idle"}, 64'(bus.shift_idle), 64'd1);
  endtask

  initial begin
    int n;
    int nrd;
    reset            = 1'b1;
    bus.shift_start  = 1'b0;
    bus.start_addr   = '0;
    bus.img_size     = '0;
    bus.serial_ready = 1'b1;
    bus.sram_rdata   = '0;
`ifdef J_SHIFTER_ABORT_EN
    bus.shift_abort  = 1'b0;
`endif
    mem[32'h100] = 32'hA5A5_0001;
    repeat (3) @(negedge clk);
    check("rst_sram_en", 64'(bus.sram_en), 64'd0);
    check("rst_addr", 64'(bus.sram_addr), 64'd0);
    check("rst_ser_en", 64'(bus.serial_en), 64'd0);
    check("rst_ser_out", 64'(bus.serial_output), 64'd0);
    check("rst_idle", 64'(bus.shift_idle), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    run(AW'(32'h100), AW'(0), 1'b0, 1'b0, 1'b1, "t1");
    run(AW'(32'h100), AW'(3), 1'b0, 1'b0, 1'b0, "t2");
    run(AW'(32'h100), AW'(3), 1'b1, 1'b0, 1'b0, "t3");
    run(AW'(32'h3FFFC), AW'(1), 1'b0, 1'b1, 1'b0, "t4");

    // Reset while bit 17 of word 1 is on the output.
    bus.start_addr  = AW'(32'h100);
    bus.img_size    = AW'(3);
    bus.shift_start = 1'b1;
    @(negedge clk);
    bus.shift_start = 1'b0;
    n = 0;
    while (bit_q.size() < 49 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach", 64'(n < 500), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_sram_en", 64'(bus.sram_en), 64'd0);
    check("t5_addr", 64'(bus.sram_addr), 64'd0);
    check("t5_ser_en", 64'(bus.serial_en), 64'd0);
    check("t5_ser_out", 64'(bus.serial_output), 64'd0);
    check("t5_idle", 64'(bus.shift_idle), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(AW'(32'h200), AW'(0), 1'b0, 1'b0, 1'b1, "t5b");

`ifdef J_SHIFTER_ABORT_EN
    rd_q.delete(); bit_q.delete(); t_q.delete();
    bus.start_addr  = AW'(32'h300);
    bus.img_size    = AW'(7);
    bus.shift_start = 1'b1;
    @(negedge clk);
    bus.shift_start = 1'b0;
    n = 0;
    while (bit_q.size() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach", 64'(n < 500), 64'd1);
    bus.shift_abort = 1'b1;
    @(negedge clk);
    bus.shift_abort = 1'b0;
    check("t6_ser_en", 64'(bus.serial_en), 64'd0);
    check("t6_idle", 64'(bus.shift_idle), 64'd1);
    nrd = rd_q.size();
    repeat (10) @(negedge clk);
    check("t6_no_reads", 64'(rd_q.size()), 64'(nrd));
    check("t6_nbits", 64'(bit_q.size()), 64'd5);
    run(AW'(32'h100), AW'(0), 1'b0, 1'b0, 1'b1, "t6b");
`else
    nrd = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
